pcm_frame_sched: RTL and testbench

- Frame scheduler for the PCM transmit path. Builds fixed-length PCM minor frames: a sync word, then WORDS_PER_FRAME payload words.
- Shares the single serial bit lane between two word requesters (A, B) using round-robin arbitration, and inserts FILL_WORD into idle slots.
- Drives the serial bit and the frame-aligned code-type selection into the downstream PCM encoder, one bit per clk_temp cycle.

---
 rtl/pcm_pkg.sv | 29 ++
 rtl/pcm_rr_arb.sv | 43 ++++
 rtl/pcm_frame_sched.sv | 201 ++++++++++++++++++++
 tb/tb_pcm_frame_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM transmit frame scheduler.
package pcm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [2:0] PAT_RNRZL = 3'd0;
  localparam logic [2:0] PAT_NRZL  = 3'd1;
  localparam logic [2:0] PAT_NRZM  = 3'd2;
  localparam logic [2:0] PAT_NRZS  = 3'd3;

  localparam logic [23:0] SYNC_PATTERN_DEF = 24'hFAF320;
  localparam logic [7:0]  FILL_WORD_DEF    = 8'hAA;

  // Unsupported code types fall back to NRZ-L.
  function automatic logic [2:0] pat_map(input logic [2:0] cfg);
    logic [2:0] res;
    if (cfg > PAT_NRZS) begin
      res = PAT_NRZL;
    end else begin
      res = cfg;
    end
    return res;
  endfunction

endpackage

// File: rtl/pcm_rr_arb.sv
// Two-requester round-robin arbiter. Pure combinational decision; the
// pointer register lives in the caller. ptr_i=0 favours A, 1 favours B.
module pcm_rr_arb
  import pcm_pkg::*;
(
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  logic load_i,
  input  logic ptr_i,
  output logic a_gnt_o,
  output logic b_gnt_o,
  output logic ptr_d_o
);

  // Grant at most one requester per load strobe and point away from the winner.
  always_comb begin
    a_gnt_o = 1'b0;
    b_gnt_o = 1'b0;
    ptr_d_o = ptr_i;
    if (load_i) begin
      if (a_valid_i && b_valid_i) begin
        if (ptr_i) begin
          b_gnt_o = 1'b1;
          ptr_d_o = 1'b0;
        end else begin
          a_gnt_o = 1'b1;
          ptr_d_o = 1'b1;
        end
      end else if (a_valid_i) begin
        a_gnt_o = 1'b1;
        ptr_d_o = 1'b1;
      end else if (b_valid_i) begin
        b_gnt_o = 1'b1;
        ptr_d_o = 1'b0;
      end else begin
        ptr_d_o = ptr_i;
      end
    end else begin
      ptr_d_o = ptr_i;
    end
  end

endmodule

// File: rtl/pcm_frame_sched.sv
// PCM minor-frame scheduler: sync word followed by WORDS_PER_FRAME payload
// words, serialised MSB first, one bit per clk_temp cycle.
module pcm_frame_sched
  import pcm_pkg::*;
#(
  parameter int unsigned             WORD_W          = 8,
  parameter int unsigned             SYNC_W          = 24,
  parameter logic [SYNC_W-1:0]       SYNC_PATTERN    = SYNC_PATTERN_DEF,
  parameter int unsigned             WORDS_PER_FRAME = 16,
  parameter logic [WORD_W-1:0]       FILL_WORD       = FILL_WORD_DEF
) (
  input  logic              clk_temp,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic [2:0]        pattern_cfg_i,
  input  logic              a_valid_i,
  input  logic [WORD_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [WORD_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              bit_o,
  output logic [2:0]        pattern_o,
  output logic              frame_start_o,
  output logic              word_start_o,
  output logic [15:0]       frame_cnt_o,
  output logic              busy_o
);

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_W - 1);
  localparam logic [7:0] WORD_LAST = 8'(WORD_W - 1);
  localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_FRAME - 1);

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          word_q, word_d;
  logic [SYNC_W-1:0]   sh_q, sh_d;
  logic                ptr_q, ptr_d;
  logic                frame_start_q, frame_start_d;
  logic                word_start_q, word_start_d;
  logic                busy_q, busy_d;
  logic [2:0]          pat_q, pat_d;
  logic [15:0]         fcnt_q, fcnt_d;

  logic                load_s;
  logic                end_s;
  logic                start_s;
  logic                a_gnt_s, b_gnt_s, ptr_nx_s;
  logic [WORD_W-1:0]   load_word_s;
  logic [SYNC_W-1:0]   load_sh_s;

  // Slot boundaries: load on the last bit of sync or of any word but the final one.
  always_comb begin
    load_s = 1'b0;
    end_s  = 1'b0;
    if (state_q == SYNC) begin
      load_s = (cnt_q == SYNC_LAST);
    end else if (state_q == DATA) begin
      load_s = (cnt_q == WORD_LAST) && (word_q != LAST_WORD);
      end_s  = (cnt_q == WORD_LAST) && (word_q == LAST_WORD);
    end else begin
      load_s = 1'b0;
      end_s  = 1'b0;
    end
    start_s = enable_i && ((state_q == IDLE) || end_s);
  end

  pcm_rr_arb u_arb (
    .a_valid_i (a_valid_i),
    .b_valid_i (b_valid_i),
    .load_i    (load_s),
    .ptr_i     (ptr_q),
    .a_gnt_o   (a_gnt_s),
    .b_gnt_o   (b_gnt_s),
    .ptr_d_o   (ptr_nx_s)
  );

  // Select the word to shift out next: granted requester or fill.
  always_comb begin
    if (a_gnt_s) begin
      load_word_s = a_data_i;
    end else if (b_gnt_s) begin
      load_word_s = b_data_i;
    end else begin
      load_word_s = FILL_WORD;
    end
  end

  // Payload words are left-aligned in the shared shift register.
  assign load_sh_s = SYNC_W'(load_word_s) << (SYNC_W - WORD_W);

  // Next-state logic for the frame FSM, counters and shift register.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    word_d        = word_q;
    sh_d          = {sh_q[SYNC_W-2:0], 1'b0};
    ptr_d         = ptr_nx_s;
    frame_start_d = 1'b0;
    word_start_d  = 1'b0;
    busy_d        = 1'b1;
    pat_d         = pat_q;
    fcnt_d        = fcnt_q;
    case (state_q)
      IDLE: begin
        sh_d   = '0;
        busy_d = 1'b0;
      end
      SYNC: begin
        if (cnt_q == SYNC_LAST) begin
          state_d      = DATA;
          cnt_d        = 8'd0;
          word_d       = 8'd0;
          sh_d         = load_sh_s;
          word_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (cnt_q == WORD_LAST) begin
          if (word_q == LAST_WORD) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            word_d  = 8'd0;
            sh_d    = '0;
            busy_d  = 1'b0;
          end else begin
            word_d       = word_q + 8'd1;
            cnt_d        = 8'd0;
            sh_d         = load_sh_s;
            word_start_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        word_d  = 8'd0;
        sh_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
    // A new frame (from IDLE or back-to-back) overrides the slot bookkeeping.
    if (start_s) begin
      state_d       = SYNC;
      cnt_d         = 8'd0;
      word_d        = 8'd0;
      sh_d          = SYNC_PATTERN;
      frame_start_d = 1'b1;
      word_start_d  = 1'b0;
      busy_d        = 1'b1;
      pat_d         = pat_map(pattern_cfg_i);
      fcnt_d        = fcnt_q + 16'd1;
    end else begin
      pat_d  = pat_q;
      fcnt_d = fcnt_q;
    end
  end

  // State and output registers; async reset returns everything to idle.
  always_ff @(posedge clk_temp or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      word_q        <= 8'd0;
      sh_q          <= '0;
      ptr_q         <= 1'b0;
      frame_start_q <= 1'b0;
      word_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      pat_q         <= 3'd0;
      fcnt_q        <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      word_q        <= word_d;
      sh_q          <= sh_d;
      ptr_q         <= ptr_d;
      frame_start_q <= frame_start_d;
      word_start_q  <= word_start_d;
      busy_q        <= busy_d;
      pat_q         <= pat_d;
      fcnt_q        <= fcnt_d;
    end
  end

  // Ready is the acceptance handshake: the grant qualified by the registered
  // load-slot position, so it can only ever fire in a load cycle.
  assign a_ready_o     = a_gnt_s;
  assign b_ready_o     = b_gnt_s;
  assign bit_o         = sh_q[SYNC_W-1];
  assign pattern_o     = pat_q;
  assign frame_start_o = frame_start_q;
  assign word_start_o  = word_start_q;
  assign frame_cnt_o   = fcnt_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_pcm_frame_sched.sv
// Self-checking bench for pcm_frame_sched: frame-position reference model,
// per-cycle comparison, directed scenarios plus randomized traffic.
module tb_pcm_frame_sched;

  localparam int FL = 152;

  logic        clk_temp = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        enable_i = 1'b0;
  logic [2:0]  pattern_cfg_i = 3'd0;
  logic        a_valid_i = 1'b0;
  logic [7:0]  a_data_i = 8'd0;
  logic        b_valid_i = 1'b0;
  logic [7:0]  b_data_i = 8'd0;
  logic        a_ready_o, b_ready_o, bit_o, frame_start_o, word_start_o, busy_o;
  logic [2:0]  pattern_o;
  logic [15:0] frame_cnt_o;

  always #5 clk_temp = ~clk_temp;

  pcm_frame_sched dut (
    .clk_temp      (clk_temp),
    .rst_n_i       (rst_n_i),
    .enable_i      (enable_i),
    .pattern_cfg_i (pattern_cfg_i),
    .a_valid_i     (a_valid_i),
    .a_data_i      (a_data_i),
    .a_ready_o     (a_ready_o),
    .b_valid_i     (b_valid_i),
    .b_data_i      (b_data_i),
    .b_ready_o     (b_ready_o),
    .bit_o         (bit_o),
    .pattern_o     (pattern_o),
    .frame_start_o (frame_start_o),
    .word_start_o  (word_start_o),
    .frame_cnt_o   (frame_cnt_o),
    .busy_o        (busy_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: position inside the 152-cycle frame
  bit          m_run;
  int          m_pos;
  logic [7:0]  m_word;
  bit          m_ptr;
  logic [2:0]  m_pat;
  logic [15:0] m_fcnt;
  bit          m_fs, m_ws;
  logic [23:0] sync_v = 24'hFAF320;

  // DUT-stream deserialisers
  logic [7:0]  wacc;
  int          wbits = 0;
  logic [7:0]  words[$];
  logic [23:0] sacc;
  int          sbits = 0;
  logic [23:0] syncs[$];
  int          fs_cyc[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_load();
    return m_run && (m_pos == 23 || (m_pos >= 24 && (m_pos - 24) % 8 == 7 && m_pos != FL - 1));
  endfunction

  // 0 none, 1 A, 2 B
  function automatic int m_grant();
    if (!m_load()) return 0;
    if (a_valid_i && b_valid_i) return m_ptr ? 2 : 1;
    if (a_valid_i) return 1;
    if (b_valid_i) return 2;
    return 0;
  endfunction

  function automatic logic m_bit();
    if (!m_run) return 1'b0;
    if (m_pos < 24) return sync_v[23 - m_pos];
    return m_word[7 - ((m_pos - 24) % 8)];
  endfunction

  task automatic m_reset();
    m_run = 0; m_pos = 0; m_word = 8'd0; m_ptr = 0;
    m_pat = 3'd0; m_fcnt = 16'd0; m_fs = 0; m_ws = 0;
    wbits = 0; sbits = 0;
  endtask

  task automatic m_start();
    m_run = 1; m_pos = 0; m_fs = 1; m_ws = 0;
    m_pat = (pattern_cfg_i > 3'd3) ? 3'd1 : pattern_cfg_i;
    m_fcnt = m_fcnt + 16'd1;
  endtask

  task automatic m_step();
    int g;
    if (!rst_n_i) begin
      m_reset();
    end else begin
      g = m_grant();
      m_fs = 0; m_ws = 0;
      if (!m_run) begin
        if (enable_i) m_start();
      end else if (m_load()) begin
        m_word = (g == 1) ? a_data_i : (g == 2) ? b_data_i : 8'hAA;
        if (g == 1) m_ptr = 1;
        if (g == 2) m_ptr = 0;
        m_ws = 1;
        m_pos++;
      end else if (m_pos == FL - 1) begin
        if (enable_i) m_start(); else m_run = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic check_all();
    int g;
    g = m_grant();
    chk("bit", bit_o, m_bit());
    chk("frame_start", frame_start_o, m_fs);
    chk("word_start", word_start_o, m_ws);
    chk("pattern", pattern_o, m_pat);
    chk("frame_cnt", frame_cnt_o, m_fcnt);
    chk("busy", busy_o, m_run);
    chk("a_ready", a_ready_o, g == 1);
    chk("b_ready", b_ready_o, g == 2);
    if (frame_start_o) begin
      fs_cyc.push_back(cyc);
      sacc = {23'd0, bit_o}; sbits = 1;
    end else if (sbits > 0 && sbits < 24) begin
      sacc = {sacc[22:0], bit_o}; sbits++;
    end
    if (sbits == 24) begin syncs.push_back(sacc); sbits = 0; end
    if (word_start_o) begin
      wacc = {7'd0, bit_o}; wbits = 1;
    end else if (wbits > 0 && wbits < 8) begin
      wacc = {wacc[6:0], bit_o}; wbits++;
    end
    if (wbits == 8) begin words.push_back(wacc); wbits = 0; end
  endtask

  // one clock: check away from the edge, advance the model on the edge,
  // return at the following negedge where the caller may change inputs
  task automatic cycle();
    #2;
    if (!rst_n_i) m_reset();
    check_all();
    @(posedge clk_temp);
    m_step();
    cyc++;
    @(negedge clk_temp);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (!m_fs && n < 400) begin cycle(); n++; end
    checks++;
    if (!m_fs) begin errors++; $display("FAIL wait_frame_start actual=timeout expected=start"); end
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (!(m_run && m_pos == p) && n < 400) begin cycle(); n++; end
    checks++;
    if (!(m_run && m_pos == p)) begin errors++; $display("FAIL wait_pos actual=%0d expected=%0d", m_pos, p); end
  endtask

  initial begin
    int n;
    m_reset();
    #1 rst_n_i = 1'b0;
    @(negedge clk_temp);
    for (int i = 0; i < 3; i++) cycle();
    chk("rst_bit", bit_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_fcnt", frame_cnt_o, 16'd0);

    // cold start, no requesters: three fill frames
    rst_n_i = 1'b1; enable_i = 1'b1;
    for (int i = 0; i < 307; i++) cycle();
    chk("fcnt_after3", frame_cnt_o, 16'd3);
    chk("period", fs_cyc[1] - fs_cyc[0], 152);
    chk("period2", fs_cyc[2] - fs_cyc[1], 152);
    chk("sync_word", syncs[0], 24'hFAF320);
    chk("fill_w0", words[0], 8'hAA);
    chk("fill_w15", words[15], 8'hAA);

    // both requesters held: alternate starting with A
    wait_fs();
    a_valid_i = 1'b1; a_data_i = 8'h11; b_valid_i = 1'b1; b_data_i = 8'h22;
    words.delete();
    for (int i = 0; i < 120; i++) cycle();
    chk("alt_w0", words[0], 8'h11);
    chk("alt_w1", words[1], 8'h22);
    chk("alt_w2", words[2], 8'h11);

    // only A for words 0..2, pattern change at cycle 40
    wait_fs();
    pattern_cfg_i = 3'd0;
    b_valid_i = 1'b0; a_data_i = 8'h5C;
    wait_fs();
    words.delete();
    wait_pos(40);
    a_valid_i = 1'b0; pattern_cfg_i = 3'd2;
    wait_pos(100);
    chk("pat_hold", pattern_o, 3'd0);
    chk("only_a_w0", words[0], 8'h5C);
    chk("only_a_w2", words[2], 8'h5C);
    chk("only_a_w3", words[3], 8'hAA);
    a_valid_i = 1'b1; a_data_i = 8'h11; b_valid_i = 1'b1; b_data_i = 8'h22;
    wait_fs();
    chk("pat_new", pattern_o, 3'd2);
    words.delete();
    pattern_cfg_i = 3'd6;
    wait_pos(40);
    chk("next_to_b", words[0], 8'h22);
    wait_fs();
    chk("pat_map6", pattern_o, 3'd1);

    // drop enable at cycle 10: frame runs to completion
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    wait_pos(10);
    enable_i = 1'b0;
    n = 0;
    while (busy_o && n < 400) begin cycle(); n++; end
    chk("drop_len", n, 142);
    chk("idle_bit", bit_o, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    enable_i = 1'b1;
    cycle();
    chk("reenable_fs", frame_start_o, 1'b1);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      a_valid_i = 1'($urandom_range(0, 1));
      b_valid_i = 1'($urandom_range(0, 1));
      a_data_i = 8'($urandom);
      b_data_i = 8'($urandom);
      pattern_cfg_i = 3'($urandom);
      enable_i = ($urandom_range(0, 99) < 97);
      cycle();
    end

    // reset mid-word 7 after A-only grants pointed the arbiter at B
    enable_i = 1'b1; a_valid_i = 1'b1; a_data_i = 8'h11; b_valid_i = 1'b0;
    wait_fs();
    wait_pos(83);
    rst_n_i = 1'b0;
    #1;
    chk("mrst_bit", bit_o, 1'b0);
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_fcnt", frame_cnt_o, 16'd0);
    chk("mrst_pat", pattern_o, 3'd0);
    for (int i = 0; i < 3; i++) cycle();
    rst_n_i = 1'b1; b_valid_i = 1'b1; b_data_i = 8'h22;
    words.delete();
    wait_pos(40);
    chk("restart_fcnt", frame_cnt_o, 16'd1);
    chk("restart_w0", words[0], 8'h11);
    chk("restart_w1", words[1], 8'h22);
    for (int i = 0; i < 10; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
